data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache in the MEMORY stage of the pipelined RV32I core. It sits between the execute/memory pipeline register (ALU result as address, RD2 as store data) and the word-addressed backing data memory. It returns load data to the write-back mux and raises a stall to freeze the upstream pipeline on misses and stores.

---
 rtl/cache_pkg.sv | 18 +
 rtl/data_cache_array.sv | 58 +++++
 rtl/data_cache.sv | 187 ++++++++++++++++++
 tb/tb_data_cache.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the MEM-stage data cache.
package cache_pkg;

    localparam int CACHE_DW    = 32;
    localparam int CACHE_LINES = 16;
    localparam int CACHE_WPL   = 4;

    localparam int OFFSET_W = $clog2(CACHE_WPL);
    localparam int INDEX_W  = $clog2(CACHE_LINES);
    localparam int TAG_W    = CACHE_DW - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

endpackage

// File: rtl/data_cache_array.sv
// Tag, valid and data storage for the direct-mapped data cache.
// Combinational read port, synchronous write ports.
module data_cache_array #(
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int OW = 2,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_idx,
    input  logic [OW-1:0] i_off,
    output logic          o_valid,
    output logic [TW-1:0] o_tag,
    output logic [DW-1:0] o_word,
    input  logic          i_word_we,
    input  logic [OW-1:0] i_woff,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_tag_we,
    input  logic [TW-1:0] i_tag,
    input  logic          i_clr
);

    localparam int LINES = 1 << IW;
    localparam int WORDS = 1 << (IW + OW);

    logic [DW-1:0]    r_data [WORDS];
    logic [TW-1:0]    r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_word  = r_data[{i_idx, i_off}];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
        end else if (i_clr) begin
            r_valid[i_idx] <= 1'b0;
        end
    end

    // Storage carries no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_idx] <= i_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (i_word_we) begin
            r_data[{i_idx, i_woff}] <= i_wdata;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Refills whole lines on load misses; stores always go to memory.
module data_cache
    import cache_pkg::*;
#(
    parameter int DW    = CACHE_DW,
    parameter int LINES = CACHE_LINES,
    parameter int WPL   = CACHE_WPL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int OW = $clog2(WPL);
    localparam int IW = $clog2(LINES);
    localparam int TW = DW - IW - OW - 2;
    localparam logic [OW-1:0] LAST = OW'(WPL - 1);

    state_t        r_state;
    logic [OW-1:0] r_beat;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_done;

    logic [OW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_valid;
    logic [TW-1:0] w_line_tag;
    logic [DW-1:0] w_word;
    logic          w_hit;
    logic          w_ack;
    logic [OW-1:0] w_beat_nxt;
    logic          w_stall;
    logic          w_load_hit;
    logic          w_clr;
    logic          w_word_we;
    logic          w_tag_we;
    logic [OW-1:0] w_woff;
    logic [DW-1:0] w_wdata;
    logic          w_unused;

    assign w_off      = addr_i[OW+1:2];
    assign w_idx      = addr_i[OW+IW+1:OW+2];
    assign w_tag      = addr_i[DW-1:OW+IW+2];
    assign w_unused   = ^addr_i[1:0];
    assign w_hit      = w_valid && (w_line_tag == w_tag);
    assign w_ack      = mem_ack_i && r_mem_req;
    assign w_beat_nxt = r_beat + 1'b1;

    data_cache_array #(
        .DW(DW),
        .IW(IW),
        .OW(OW),
        .TW(TW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_idx    (w_idx),
        .i_off    (w_off),
        .o_valid  (w_valid),
        .o_tag    (w_line_tag),
        .o_word   (w_word),
        .i_word_we(w_word_we),
        .i_woff   (w_woff),
        .i_wdata  (w_wdata),
        .i_tag_we (w_tag_we),
        .i_tag    (w_tag),
        .i_clr    (w_clr)
    );

    always_comb begin
        w_stall    = 1'b0;
        w_load_hit = 1'b0;
        w_clr      = 1'b0;
        w_word_we  = 1'b0;
        w_tag_we   = 1'b0;
        w_woff     = w_off;
        w_wdata    = wdata_i;
        unique case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (we_i) begin
                        w_stall = !r_done;
                    end else if (w_hit) begin
                        w_load_hit = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_clr   = 1'b1;
                    end
                end
            end
            REFILL: begin
                w_stall   = 1'b1;
                w_woff    = r_beat;
                w_wdata   = mem_rdata_i;
                w_word_we = w_ack;
                w_tag_we  = w_ack && (r_beat == LAST);
            end
            WRITE: begin
                w_stall   = 1'b1;
                w_wdata   = r_mem_wdata;
                w_word_we = w_ack && w_hit;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    // r_done marks the store completion cycle so the held store is not reissued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_i && we_i && !r_done) begin
                        r_state     <= WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {addr_i[DW-1:2], 2'b00};
                        r_mem_wdata <= wdata_i;
                    end else if (req_i && !we_i && !w_hit) begin
                        r_state    <= REFILL;
                        r_beat     <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {addr_i[DW-1:OW+2], {OW{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (w_ack) begin
                        if (r_beat == LAST) begin
                            r_state   <= IDLE;
                            r_beat    <= '0;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_beat     <= w_beat_nxt;
                            r_mem_addr <= {r_mem_addr[DW-1:OW+2], w_beat_nxt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (w_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o     = w_stall;
    assign rdata_o     = w_load_hit ? w_word : '0;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache with a slow/fast memory responder.
module tb_data_cache;

    localparam int DW    = 32;
    localparam int LINES = 16;
    localparam int WPL   = 4;
    localparam int LB    = WPL * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic          we_i;
    logic [DW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    data_cache #(
        .DW(DW),
        .LINES(LINES),
        .WPL(WPL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] bus_mem[int unsigned];
    bit          mv[LINES];
    int unsigned la[LINES];

    int ack_delay = 0;
    bit stray     = 1'b0;
    int acks      = 0;

    function automatic logic [31:0] init_word(int unsigned a);
        if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + (a - 32'h100) / 4;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bus_rd(int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Backing memory: acks after ack_delay waiting cycles, checks every beat.
    initial begin
        int          wait_cnt = 0;
        bit          p_req = 1'b0;
        bit          p_ack = 1'b0;
        bit          p_rst = 1'b1;
        bit          p_we = 1'b0;
        logic [31:0] p_addr = '0;
        logic [31:0] p_wd = '0;
        beat_t       e;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            #1;
            if (p_req && !p_ack && !p_rst) begin
                check("req_hold", 32'({mem_req_o, mem_we_o}), 32'({1'b1, p_we}));
                check("addr_hold", mem_addr_o, p_addr);
                check("wdata_hold", mem_wdata_o, p_wd);
            end
            p_req  = mem_req_o;
            p_we   = mem_we_o;
            p_addr = mem_addr_o;
            p_wd   = mem_wdata_o;
            p_rst  = rst;
            p_ack  = 1'b0;
            mem_ack_i = 1'b0;
            if (stray && !mem_req_o) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hBAD0_BAD0;
                stray       = 1'b0;
            end else if (mem_req_o && !rst) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt  = 0;
                    mem_ack_i = 1'b1;
                    p_ack     = 1'b1;
                    acks++;
                    if (exp_beats.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got addr %h we %0d, required none",
                                 mem_addr_o, mem_we_o);
                    end else begin
                        e = exp_beats.pop_front();
                        check("beat_we", 32'(mem_we_o), 32'(e.we));
                        check("beat_addr", mem_addr_o, e.addr);
                        if (e.we) check("beat_wdata", mem_wdata_o, e.data);
                    end
                    if (mem_we_o) bus_mem[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = bus_rd(mem_addr_o);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Load-data monitor.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && req_i && !we_i && !stall_o) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load: got %h, required none", rdata_o);
                end else begin
                    check("load_data", rdata_o, exp_rd.pop_front());
                end
            end else begin
                check("rdata_zero", rdata_o, 32'h0);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        exp_beats.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_i = 1'b0;
        end
    endtask

    task automatic access(input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
        int unsigned wa   = a & ~32'h3;
        int unsigned base = a & ~32'(LB - 1);
        int          idx  = int'((a / LB) % LINES);
        int          n    = 0;
        int          exp_lat;
        bit          done = 1'b0;
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = wd;
        if (we) begin
            exp_beats.push_back('{1'b1, wa, wd});
            ref_mem[wa] = wd;
            exp_lat = 3 + ack_delay;
        end else begin
            if (mv[idx] && la[idx] == base) begin
                exp_lat = 1;
            end else begin
                for (int b = 0; b < WPL; b++)
                    exp_beats.push_back('{1'b0, base + 4 * b, 32'h0});
                mv[idx] = 1'b1;
                la[idx] = base;
                exp_lat = 2 + WPL * (ack_delay + 1);
            end
            exp_rd.push_back(ref_rd(wa));
        end
        while (!done && n < 400) begin
            #1;
            n++;
            if (!stall_o) done = 1'b1;
            else @(negedge clk);
        end
        check(we ? "store_latency" : "load_latency", 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int a0;
        int k;
        rst     = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        do_reset();
        #1;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_mem_we", 32'(mem_we_o), 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);

        access(1'b0, 32'h100, 0);
        access(1'b0, 32'h108, 0);
        access(1'b0, 32'h500, 0);
        access(1'b0, 32'h100, 0);
        access(1'b1, 32'h104, 32'hDEAD_BEEF);
        access(1'b0, 32'h104, 0);
        access(1'b1, 32'h900, 32'h0BAD_F00D);
        access(1'b0, 32'h10C, 0);
        access(1'b0, 32'h900, 0);
        idle(2);

        ack_delay = 3;
        access(1'b0, 32'h200, 0);
        access(1'b1, 32'h208, 32'h1357_9BDF);
        access(1'b0, 32'h208, 0);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            ack_delay = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            access($urandom_range(0, 2) == 0,
                   32'(($urandom_range(0, 7) << 10) | ($urandom_range(0, 255) << 2)
                       | $urandom_range(0, 3)),
                   $urandom);
        end
        idle(2);

        // Abandon a refill while beat 2 is outstanding.
        do_reset();
        ack_delay = 2;
        a0 = acks;
        for (int b = 0; b < WPL; b++)
            exp_beats.push_back('{1'b0, 32'h100 + 4 * b, 32'h0});
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h100;
        k = 0;
        while (acks < a0 + 2 && k < 100) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("beats_before_rst", 32'(acks - a0), 32'd2);
        @(negedge clk);
        rst   = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req_o), 32'h0);
        check("abort_stall", 32'(stall_o), 32'h0);
        clear_model();
        stray = 1'b1;
        idle(3);
        ack_delay = 0;
        access(1'b0, 32'h100, 0);
        access(1'b0, 32'h10C, 0);
        idle(2);

        check("beats_left", 32'(exp_beats.size()), 32'h0);
        check("loads_left", 32'(exp_rd.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
